// File: rtl/rx_mensagem_torreta_pkg.sv
// rx_mensagem_torreta_pkg: shared state encodings, ASCII constants and helpers for the turret message receiver.
package rx_mensagem_torreta_pkg;
  localparam int FRAME_LEN = 8;
  localparam int DATA_W = 7;
  localparam logic [DATA_W-1:0] ASCII_ZERO = 7'h30;
  localparam logic [DATA_W-1:0] ASCII_VIRGULA = 7'h2C;
  localparam logic [DATA_W-1:0] ASCII_CERQUILHA = 7'h23;
  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, PARADA} rx_estado_t;
  typedef enum logic [1:0] {ANGULO, VIRGULA, DISTANCIA, TERMINADOR} parser_estado_t;
  function automatic logic eh_digito(input logic [DATA_W-1:0] c);
    return c >= ASCII_ZERO && c <= ASCII_ZERO + 7'd9;
  endfunction
  function automatic logic [3:0] bcd(input logic [DATA_W-1:0] c);
    return c[3:0];
  endfunction
endpackage

// File: rtl/rx_mensagem_torreta_rx_serial.sv
// rx_serial_7O1: 7-bit odd-parity UART receiver with input synchronizer and mid-bit sampling.
module rx_serial_7O1
  import rx_mensagem_torreta_pkg::*;
#(
  parameter int CLKS_POR_BIT = 434,
  parameter int N_SYNC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              entrada_serial,
  output logic [DATA_W-1:0] dado,
  output logic              pronto,
  output logic              erro
);
  localparam int CW = $clog2(CLKS_POR_BIT);
  logic [N_SYNC-1:0] sync_q;
  logic ant_q, par_q, par_d, pronto_q, pronto_d, erro_q, erro_d;
  rx_estado_t est_q, est_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic linha, meio, tick;
  assign linha = sync_q[N_SYNC-1];
  assign meio = cnt_q == CW'(CLKS_POR_BIT / 2 - 1);
  assign tick = cnt_q == CW'(CLKS_POR_BIT - 1);
  assign dado = sh_q;
  assign pronto = pronto_q;
  assign erro = erro_q;
  // Start only on a falling edge, so a break must return high before re-arming.
  always_comb begin
    est_d = est_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    pronto_d = 1'b0;
    erro_d = 1'b0;
    case (est_q)
      OCIOSO: begin
        cnt_d = '0;
        bit_d = '0;
        if (ant_q && !linha) est_d = INICIO;
      end
      INICIO: if (meio) begin
        cnt_d = '0;
        est_d = linha ? OCIOSO : DADOS;
      end
      DADOS: if (tick) begin
        cnt_d = '0;
        sh_d = {linha, sh_q[DATA_W-1:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'(DATA_W - 1)) est_d = PARIDADE;
      end
      PARIDADE: if (tick) begin
        cnt_d = '0;
        par_d = ^{linha, sh_q};
        est_d = PARADA;
      end
      default: if (tick) begin
        cnt_d = '0;
        est_d = OCIOSO;
        pronto_d = linha & par_q;
        erro_d = ~(linha & par_q);
      end
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      ant_q <= 1'b1;
      est_q <= OCIOSO;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      pronto_q <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N_SYNC-2:0], entrada_serial};
      ant_q <= linha;
      est_q <= est_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      pronto_q <= pronto_d;
      erro_q <= erro_d;
    end
  end
endmodule

// File: rtl/rx_mensagem_torreta.sv
// rx_mensagem_torreta: parses "ddd,ddd#" frames from the serial receiver into held BCD angle/distance digits.
module rx_mensagem_torreta
  import rx_mensagem_torreta_pkg::*;
#(
  parameter int CLKS_POR_BIT = 434,
  parameter int N_SYNC = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [3:0] angulo_centena,
  output logic [3:0] angulo_dezena,
  output logic [3:0] angulo_unidade,
  output logic [3:0] distancia_centena,
  output logic [3:0] distancia_dezena,
  output logic [3:0] distancia_unidade,
  output logic       mensagem_valida,
  output logic       erro_paridade,
  output logic       erro_formato,
  output logic [3:0] db_estado
);
  logic [DATA_W-1:0] dado;
  logic pronto, erro;
  parser_estado_t pst_q, pst_d;
  logic [1:0] dig_q, dig_d;
  logic [2:0][3:0] sa_q, sd_q, oa_q, od_q;
  logic mv_q, mv_d, ef_q, ef_d, ga, gd;
  rx_serial_7O1 #(.CLKS_POR_BIT(CLKS_POR_BIT), .N_SYNC(N_SYNC)) u_rx (
    .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
    .dado(dado), .pronto(pronto), .erro(erro)
  );
  assign {angulo_centena, angulo_dezena, angulo_unidade} = {oa_q[0], oa_q[1], oa_q[2]};
  assign {distancia_centena, distancia_dezena, distancia_unidade} = {od_q[0], od_q[1], od_q[2]};
  assign mensagem_valida = mv_q;
  assign erro_formato = ef_q;
  assign erro_paridade = erro;
  assign db_estado = {2'b00, pst_q};
  always_comb begin
    pst_d = pst_q;
    dig_d = dig_q;
    mv_d = 1'b0;
    ef_d = 1'b0;
    ga = 1'b0;
    gd = 1'b0;
    if (erro) begin
      pst_d = ANGULO;
      dig_d = '0;
    end else if (pronto) begin
      case (pst_q)
        ANGULO, DISTANCIA: if (eh_digito(dado)) begin
          ga = pst_q == ANGULO;
          gd = pst_q == DISTANCIA;
          dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
          if (dig_q == 2'd2) pst_d = (pst_q == ANGULO) ? VIRGULA : TERMINADOR;
        end else ef_d = 1'b1;
        VIRGULA: if (dado == ASCII_VIRGULA) pst_d = DISTANCIA; else ef_d = 1'b1;
        default: if (dado == ASCII_CERQUILHA) begin
          mv_d = 1'b1;
          pst_d = ANGULO;
        end else ef_d = 1'b1;
      endcase
      if (ef_d) begin
        pst_d = ANGULO;
        dig_d = '0;
      end
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pst_q <= ANGULO;
      dig_q <= '0;
      sa_q <= '0;
      sd_q <= '0;
      oa_q <= '0;
      od_q <= '0;
      mv_q <= 1'b0;
      ef_q <= 1'b0;
    end else begin
      pst_q <= pst_d;
      dig_q <= dig_d;
      mv_q <= mv_d;
      ef_q <= ef_d;
      if (ga) sa_q[dig_q] <= bcd(dado);
      if (gd) sd_q[dig_q] <= bcd(dado);
      if (mv_d) begin
        oa_q <= sa_q;
        od_q <= sd_q;
      end
    end
  end
endmodule

// File: tb/tb_rx_mensagem_torreta.sv
// tb_rx_mensagem_torreta: directed frames with a scoreboard of expected pulses and the digits visible at each pulse.
module tb_rx_mensagem_torreta;
  localparam int CPB = 40;
  localparam logic [2:0] K_MV = 3'b100, K_EP = 3'b010, K_EF = 3'b001;
  logic clock = 1'b0, reset = 1'b1, entrada_serial = 1'b1;
  logic [3:0] ac, ad, au, dc, dd, du, db_estado;
  logic mensagem_valida, erro_paridade, erro_formato;
  rx_mensagem_torreta #(.CLKS_POR_BIT(CPB), .N_SYNC(2)) dut (
    .clock(clock), .reset(reset), .entrada_serial(entrada_serial),
    .angulo_centena(ac), .angulo_dezena(ad), .angulo_unidade(au),
    .distancia_centena(dc), .distancia_dezena(dd), .distancia_unidade(du),
    .mensagem_valida(mensagem_valida), .erro_paridade(erro_paridade),
    .erro_formato(erro_formato), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  typedef struct {logic [2:0] k; logic [11:0] a; logic [11:0] d;} ev_t;
  ev_t sb[$];
  int n_chk = 0, n_pass = 0;
  logic [11:0] cur_a = 12'h000, cur_d = 12'h000;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic push(input logic [2:0] k);
    ev_t e;
    e.k = k;
    e.a = cur_a;
    e.d = cur_d;
    sb.push_back(e);
  endtask
  task automatic push_valid(input logic [11:0] a, input logic [11:0] d);
    cur_a = a;
    cur_d = d;
    push(K_MV);
  endtask
  always @(negedge clock) begin
    ev_t e;
    if (mensagem_valida || erro_paridade || erro_formato) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_event: got %b expected none", {mensagem_valida, erro_paridade, erro_formato});
      end else begin
        e = sb.pop_front();
        chk("event_kind", {29'd0, mensagem_valida, erro_paridade, erro_formato}, {29'd0, e.k});
        chk("event_digits", {8'd0, ac, ad, au, dc, dd, du}, {8'd0, e.a, e.d});
      end
    end
  end
  task automatic bitt(input logic b);
    entrada_serial = b;
    repeat (CPB) @(posedge clock);
  endtask
  task automatic send_char(input logic [6:0] c, input logic bad);
    bitt(1'b0);
    for (int i = 0; i < 7; i++) bitt(c[i]);
    bitt(~^c ^ bad);
    bitt(1'b1);
  endtask
  task automatic send_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_char(b[6:0], 1'b0);
    end
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 20 * CPB) begin
      @(posedge clock);
      t++;
    end
    chk("drain", sb.size(), 0);
  endtask
  task automatic chk_outs(input string nm, input logic [11:0] a, input logic [11:0] d);
    chk(nm, {8'd0, ac, ad, au, dc, dd, du}, {8'd0, a, d});
  endtask
  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_outs("reset_digits", 12'h000, 12'h000);
    chk("reset_pulses", {29'd0, mensagem_valida, erro_paridade, erro_formato}, 0);
    chk("reset_db_estado", {28'd0, db_estado}, 0);
    reset = 1'b0;
    repeat (2 * CPB) @(posedge clock);
    push_valid(12'h045, 12'h123);
    send_str("045,123#");
    drain();
    chk_outs("frame_045_123", 12'h045, 12'h123);
    push(K_EP);
    send_str("090,0");
    send_char(7'h35, 1'b1);
    send_str("2");
    push(K_EF);
    push(K_EF);
    push(K_EF);
    send_str("180,200#");
    drain();
    chk_outs("held_after_errors", 12'h045, 12'h123);
    push_valid(12'h180, 12'h200);
    send_str("180,200#");
    drain();
    chk_outs("frame_180_200", 12'h180, 12'h200);
    push(K_EF);
    send_str("12;");
    push_valid(12'h030, 12'h050);
    send_str("030,050#");
    drain();
    chk_outs("frame_030_050", 12'h030, 12'h050);
    entrada_serial = 1'b0;
    repeat (12) @(posedge clock);
    entrada_serial = 1'b1;
    repeat (15 * CPB) @(posedge clock);
    #1;
    chk("glitch_db_estado", {28'd0, db_estado}, 0);
    chk("glitch_no_event", sb.size(), 0);
    chk_outs("glitch_outputs", 12'h030, 12'h050);
    push_valid(12'h111, 12'h222);
    push_valid(12'h333, 12'h444);
    send_str("111,222#333,444#");
    drain();
    chk_outs("back_to_back", 12'h333, 12'h444);
    send_str("045,");
    bitt(1'b0);
    bitt(1'b1);
    repeat (CPB / 2) @(posedge clock);
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_outs("midframe_reset_digits", 12'h000, 12'h000);
    chk("midframe_reset_db", {28'd0, db_estado}, 0);
    reset = 1'b0;
    cur_a = 12'h000;
    cur_d = 12'h000;
    @(posedge clock);
    #1;
    chk("post_reset_pulses", {29'd0, mensagem_valida, erro_paridade, erro_formato}, 0);
    repeat (3 * CPB) @(posedge clock);
    push_valid(12'h987, 12'h654);
    send_str("987,654#");
    drain();
    chk_outs("frame_after_reset", 12'h987, 12'h654);
    repeat (3 * CPB) @(posedge clock);
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
